// File: rtl/weight_loader.sv
// weight_loader: packs a byte stream MSB-first into BITS-wide words and writes them row by row into the weight RAM
module weight_loader #(
    parameter int BITS   = 24,
    parameter int WIDTH  = 784,
    parameter int HEIGHT = 10
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [7:0]      i_in_data,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    output logic            o_wr_en,
    output logic [3:0]      o_wr_row,
    output logic [9:0]      o_wr_addr,
    output logic [BITS-1:0] o_wr_data,
    output logic            o_busy,
    output logic            o_done
);
    localparam int BYTES = (BITS + 7) / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t          r_state, w_state_nx;
    logic [3:0]      r_row, w_row_nx;
    logic [9:0]      r_addr, w_addr_nx;
    logic [CW-1:0]   r_byte, w_byte_nx;
    logic [BITS-1:0] r_shift, w_shift_nx;
    logic            w_xfer, w_last_byte, w_last_addr, w_last_row;

    assign w_xfer      = i_in_valid && o_in_ready;
    assign w_last_byte = r_byte == CW'(BYTES - 1);
    assign w_last_addr = r_addr == 10'(WIDTH - 1);
    assign w_last_row  = r_row == 4'(HEIGHT - 1);

    // Next-state logic; the cast on the shift drops excess MSBs when BITS is not a byte multiple
    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_addr_nx  = r_addr;
        w_byte_nx  = r_byte;
        w_shift_nx = r_shift;
        if (i_abort) begin
            w_state_nx = IDLE;
            w_row_nx   = '0;
            w_addr_nx  = '0;
            w_byte_nx  = '0;
            w_shift_nx = '0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    w_state_nx = LOAD;
                    w_row_nx   = '0;
                    w_addr_nx  = '0;
                    w_byte_nx  = '0;
                    w_shift_nx = '0;
                end
                LOAD: if (w_xfer) begin
                    w_shift_nx = BITS'({r_shift, i_in_data});
                    w_byte_nx  = w_last_byte ? '0 : r_byte + 1'b1;
                    w_state_nx = w_last_byte ? WRITE : LOAD;
                end
                WRITE: begin
                    w_addr_nx  = w_last_addr ? '0 : r_addr + 10'd1;
                    w_row_nx   = w_last_addr ? r_row + 4'd1 : r_row;
                    w_state_nx = (w_last_row && w_last_addr) ? DONE : LOAD;
                end
                default: begin
                    w_state_nx = IDLE;
                    w_row_nx   = '0;
                    w_addr_nx  = '0;
                    w_byte_nx  = '0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_addr  <= '0;
            r_byte  <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nx;
            r_row   <= w_row_nx;
            r_addr  <= w_addr_nx;
            r_byte  <= w_byte_nx;
            r_shift <= w_shift_nx;
        end
    end

    // Moore outputs registered from the next state; write target latched only on entry to WRITE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_in_ready <= 1'b0;
            o_wr_en    <= 1'b0;
            o_wr_row   <= '0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_in_ready <= w_state_nx == LOAD;
            o_wr_en    <= w_state_nx == WRITE;
            o_busy     <= w_state_nx == LOAD || w_state_nx == WRITE;
            o_done     <= w_state_nx == DONE;
            if (w_state_nx == WRITE) begin
                o_wr_row  <= r_row;
                o_wr_addr <= r_addr;
                o_wr_data <= w_shift_nx;
            end
        end
    end
endmodule
